// File: rtl/byte_memory_ctrl.sv
// byte_memory_ctrl: byte-addressable load/store controller in front of an
// internal synchronous RAM. It takes one request at a time, does sub-word
// stores by read-modify-write, and returns loads right-aligned with zero or
// sign extension. Byte lanes are big-endian: the lane at offset 0 holds the
// most significant byte of the RAM word.
module byte_memory_ctrl #(
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 65536
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      we,
  input  logic [1:0]                size,
  input  logic                      signed_ld,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [8*DATA_BYTES-1:0]   wdata,
  output logic                      ready,
  output logic                      done,
  output logic                      error,
  output logic [8*DATA_BYTES-1:0]   rdata
);

  localparam int unsigned W      = 8 * DATA_BYTES;
  localparam int unsigned L      = $clog2(DATA_BYTES);
  localparam int unsigned IW     = ADDR_WIDTH - L;
  localparam int unsigned RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned SW     = $clog2(W) + 1;
  localparam logic [W-1:0] ONES  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_MERGE,
    S_ERR
  } state_t;

  state_t state;
  state_t state_nxt;

  // Backing storage; never cleared by reset.
  logic [W-1:0] mem [DEPTH_WORDS];
  logic [W-1:0] ram_q;

  // Captured request.
  logic              we_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [L-1:0]      off_q;
  logic [RAM_AW-1:0] idx_q;
  logic [W-1:0]      wdata_q;

  // Request checks, evaluated on the inputs at the accepting edge.
  logic misaligned;
  logic bad_size;
  logic out_of_range;
  logic req_err;
  logic accept;

  // Lane steering.
  logic [SW-1:0]        low_sh;
  logic [SW-1:0]        top_sh;
  logic [W-1:0]         aligned_word;
  logic signed [W-1:0]  aligned_s;
  logic [W-1:0]         load_val;
  logic [W-1:0]         lane_mask;
  logic [W-1:0]         ins_data;
  logic [W-1:0]         merged;

  assign ready  = (state == S_IDLE);
  assign accept = req & ready;

  // Classify the incoming request as legal or rejected.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = |addr[1:0];
      default: misaligned = |addr[2:0];
    endcase
    bad_size     = (size == 2'd3) && (DATA_BYTES < 8);
    out_of_range = {1'b0, addr[ADDR_WIDTH-1:L]} >= (IW + 1)'(DEPTH_WORDS);
    req_err      = misaligned | bad_size | out_of_range;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = req_err ? S_ERR : S_READ;
      S_READ:  state_nxt = we_q ? S_MERGE : S_LOAD;
      S_LOAD:  state_nxt = S_IDLE;
      S_MERGE: state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the request on acceptance so later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= we;
      sgn_q   <= signed_ld;
      size_q  <= size;
      off_q   <= addr[L-1:0];
      idx_q   <= addr[L +: RAM_AW];
      wdata_q <= wdata;
    end
  end

  // Shift amounts: low_sh moves lane k to the top, top_sh drops the unused
  // lanes below an n-byte field. Size 3 on a 4-byte RAM is rejected earlier,
  // so its shift value there is irrelevant.
  always_comb begin
    low_sh = SW'({off_q, 3'b000});
    top_sh = '0;
    case (size_q)
      2'd0:    top_sh = SW'(W - 8);
      2'd1:    top_sh = SW'(W - 16);
      2'd2:    top_sh = SW'(W - 32);
      default: top_sh = (W >= 64) ? SW'(W - 64) : '0;
    endcase
  end

  // Load extraction and store merge. Left-justifying the selected field
  // first lets one arithmetic right shift do both alignment and sign fill;
  // a full-width access has top_sh=0, so signed_ld has no effect there.
  always_comb begin
    aligned_word = ram_q << low_sh;
    aligned_s    = aligned_word;
    if (sgn_q) load_val = aligned_s >>> top_sh;
    else       load_val = aligned_word >> top_sh;
    lane_mask = (ONES << top_sh) >> low_sh;
    ins_data  = (wdata_q << top_sh) >> low_sh;
    merged    = (ram_q & ~lane_mask) | (ins_data & lane_mask);
  end

  // RAM port: registered read in READ, write on the MERGE leaving edge.
  // Reset forces the state out of MERGE asynchronously, so a store caught
  // by reset is never written.
  always_ff @(posedge clk) begin
    if (state == S_READ)  ram_q <= mem[idx_q];
    if (state == S_MERGE) mem[idx_q] <= merged;
  end

  // Completion pulse, error flag and load result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done  <= 1'b0;
      error <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          done  <= 1'b1;
          error <= 1'b0;
          rdata <= load_val;
        end
        S_MERGE: begin
          done  <= 1'b1;
          error <= 1'b0;
        end
        S_ERR: begin
          done  <= 1'b1;
          error <= 1'b1;
          rdata <= '0;
        end
        default: begin
          done  <= 1'b0;
          error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_memory_ctrl.sv
// tb_byte_memory_ctrl: directed checks of byte_memory_ctrl with 4-byte and
// 8-byte RAM words, using hand-computed expected values.
module tb_byte_memory_ctrl;

  logic        clk;
  logic        reset;
  logic        req4;
  logic        req8;
  logic        we_i;
  logic [1:0]  size_i;
  logic        sgn_i;
  logic [31:0] addr_i;
  logic [63:0] wdata_i;

  logic        ready4, done4, error4;
  logic [31:0] rdata4;
  logic        ready8, done8, error8;
  logic [63:0] rdata8;

  int unsigned n_tests;
  int unsigned n_fail;

  byte_memory_ctrl #(
    .DATA_BYTES (4),
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(256)
  ) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .req      (req4),
    .we       (we_i),
    .size     (size_i),
    .signed_ld(sgn_i),
    .addr     (addr_i),
    .wdata    (wdata_i[31:0]),
    .ready    (ready4),
    .done     (done4),
    .error    (error4),
    .rdata    (rdata4)
  );

  byte_memory_ctrl #(
    .DATA_BYTES (8),
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(256)
  ) u_dut8 (
    .clk      (clk),
    .reset    (reset),
    .req      (req8),
    .we       (we_i),
    .size     (size_i),
    .signed_ld(sgn_i),
    .addr     (addr_i),
    .wdata    (wdata_i),
    .ready    (ready8),
    .done     (done8),
    .error    (error8),
    .rdata    (rdata8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete access on the selected DUT (wide=1 -> 8-byte instance).
  task automatic run_access(input bit wide, input logic wr, input logic [1:0] sz,
                            input logic sgn, input logic [31:0] a, input logic [63:0] wd,
                            input bit exp_err, input logic [63:0] exp_data, input string tag);
    int unsigned lat;
    int unsigned guard;
    guard = 0;
    while (!(wide ? ready8 : ready4) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "/ready_in"}, 64'(wide ? ready8 : ready4), 64'd1);
    we_i    = wr;
    size_i  = sz;
    sgn_i   = sgn;
    addr_i  = a;
    wdata_i = wd;
    if (wide) req8 = 1'b1;
    else      req4 = 1'b1;
    @(posedge clk); #1;
    req4    = 1'b0;
    req8    = 1'b0;
    we_i    = ~wr;
    size_i  = ~sz;
    sgn_i   = ~sgn;
    addr_i  = 32'hFFFF_FFFF;
    wdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
    check({tag, "/busy"}, 64'(wide ? ready8 : ready4), 64'd0);
    lat = 0;
    while (!(wide ? done8 : done4) && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (!(wide ? done8 : done4))
        check({tag, "/busy_wait"}, 64'(wide ? ready8 : ready4), 64'd0);
    end
    check({tag, "/latency"}, 64'(lat), exp_err ? 64'd1 : 64'd2);
    check({tag, "/ready_done"}, 64'(wide ? ready8 : ready4), 64'd1);
    check({tag, "/error"}, 64'(wide ? error8 : error4), 64'(exp_err));
    check({tag, "/rdata"}, wide ? rdata8 : 64'(rdata4), exp_data);
    @(posedge clk); #1;
    check({tag, "/done_clr"}, 64'(wide ? done8 : done4), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    req4    = 1'b0;
    req8    = 1'b0;
    we_i    = 1'b0;
    size_i  = 2'd0;
    sgn_i   = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst/ready4", 64'(ready4), 64'd1);
    check("rst/done4",  64'(done4),  64'd0);
    check("rst/error4", 64'(error4), 64'd0);
    check("rst/rdata4", 64'(rdata4), 64'd0);
    check("rst/ready8", 64'(ready8), 64'd1);
    check("rst/rdata8", rdata8,      64'd0);

    // 4-byte RAM: basic word, byte and half accesses.
    run_access(0, 1, 2'd2, 0, 32'h10, 64'hDEAD_BEEF, 0, 64'h0, "st_w10");
    run_access(0, 0, 2'd2, 0, 32'h10, 64'h0, 0, 64'hDEAD_BEEF, "ld_w10");
    run_access(0, 0, 2'd0, 0, 32'h11, 64'h0, 0, 64'h0000_00AD, "ld_bu11");
    run_access(0, 0, 2'd0, 1, 32'h11, 64'h0, 0, 64'hFFFF_FFAD, "ld_bs11");
    run_access(0, 0, 2'd0, 1, 32'h13, 64'h0, 0, 64'hFFFF_FFEF, "ld_bs13");
    run_access(0, 1, 2'd1, 0, 32'h12, 64'h1234, 0, 64'hFFFF_FFEF, "st_h12");
    run_access(0, 0, 2'd2, 0, 32'h10, 64'h0, 0, 64'hDEAD_1234, "ld_w10b");
    run_access(0, 1, 2'd0, 0, 32'h10, 64'hCCCC_CC55, 0, 64'hDEAD_1234, "st_b10");
    run_access(0, 0, 2'd2, 1, 32'h10, 64'h0, 0, 64'h55AD_1234, "ld_w10c");
    run_access(0, 0, 2'd1, 1, 32'h10, 64'h0, 0, 64'h0000_55AD, "ld_hs10");
    run_access(0, 0, 2'd1, 1, 32'h12, 64'h0, 0, 64'h0000_1234, "ld_hs12");

    // Rejected requests.
    run_access(0, 0, 2'd1, 0, 32'h13, 64'h0, 1, 64'h0, "err_h13");
    run_access(0, 0, 2'd2, 0, 32'h10, 64'h0, 0, 64'h55AD_1234, "ld_w10d");
    run_access(0, 1, 2'd2, 0, 32'h12, 64'hFFFF_FFFF, 1, 64'h0, "err_st12");
    run_access(0, 0, 2'd2, 0, 32'h10, 64'h0, 0, 64'h55AD_1234, "ld_w10e");
    run_access(0, 0, 2'd3, 0, 32'h10, 64'h0, 1, 64'h0, "err_sz3");
    run_access(0, 0, 2'd2, 0, 32'h400, 64'h0, 1, 64'h0, "err_oor");
    run_access(0, 1, 2'd2, 0, 32'h3FC, 64'hA5A5_0F0F, 0, 64'h0, "st_last");
    run_access(0, 0, 2'd2, 0, 32'h3FC, 64'h0, 0, 64'hA5A5_0F0F, "ld_last");
    run_access(0, 0, 2'd0, 1, 32'h3FD, 64'h0, 0, 64'hFFFF_FFA5, "ld_bs3fd");

    // Reset while a store of 0 to 0x10 sits in MERGE.
    run_access(0, 0, 2'd2, 0, 32'h10, 64'h0, 0, 64'h55AD_1234, "ld_pre_rst");
    we_i    = 1'b1;
    size_i  = 2'd2;
    sgn_i   = 1'b0;
    addr_i  = 32'h10;
    wdata_i = 64'h0;
    req4    = 1'b1;
    @(posedge clk); #1;
    req4 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mrst/ready", 64'(ready4), 64'd1);
    check("mrst/done",  64'(done4),  64'd0);
    check("mrst/rdata", 64'(rdata4), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("mrst/ready_after", 64'(ready4), 64'd1);
    check("mrst/done_after",  64'(done4),  64'd0);
    check("mrst/rdata_after", 64'(rdata4), 64'd0);
    run_access(0, 0, 2'd2, 0, 32'h10, 64'h0, 0, 64'h55AD_1234, "ld_post_rst");

    // 8-byte RAM.
    run_access(1, 1, 2'd3, 0, 32'h20, 64'h0123_4567_89AB_CDEF, 0, 64'h0, "d_st_d20");
    run_access(1, 0, 2'd2, 1, 32'h24, 64'h0, 0, 64'hFFFF_FFFF_89AB_CDEF, "d_ld_ws24");
    run_access(1, 0, 2'd1, 0, 32'h22, 64'h0, 0, 64'h0000_0000_0000_4567, "d_ld_hu22");
    run_access(1, 0, 2'd3, 1, 32'h20, 64'h0, 0, 64'h0123_4567_89AB_CDEF, "d_ld_d20");
    run_access(1, 0, 2'd1, 1, 32'h26, 64'h0, 0, 64'hFFFF_FFFF_FFFF_CDEF, "d_ld_hs26");
    run_access(1, 1, 2'd2, 0, 32'h20, 64'hFFFF_FFFF_1122_3344, 0, 64'hFFFF_FFFF_FFFF_CDEF, "d_st_w20");
    run_access(1, 0, 2'd3, 0, 32'h20, 64'h0, 0, 64'h1122_3344_89AB_CDEF, "d_ld_d20b");
    run_access(1, 0, 2'd0, 1, 32'h27, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFEF, "d_ld_bs27");
    run_access(1, 0, 2'd3, 0, 32'h24, 64'h0, 1, 64'h0, "d_err_mis");
    run_access(1, 0, 2'd2, 0, 32'h800, 64'h0, 1, 64'h0, "d_err_oor");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_memory_ctrl.md
# byte_memory_ctrl

Parametrised byte-addressable data-memory controller for the processor's load/store path. It accepts one request at a time over a req/ready handshake, and supports byte, half-word, word and (when configured 8 bytes wide) double-word accesses at any naturally aligned offset. Sub-word stores are done by read-modify-write. Loads are returned right-aligned, with zero or sign extension. The backing storage is an internal synchronous RAM with a one-cycle registered read, and its contents are not cleared by reset.

## Interface
Parameters:
- DATA_BYTES, 4: bytes per RAM word; legal values 4 or 8. Defines W = 8*DATA_BYTES and L = log2(DATA_BYTES).
- ADDR_WIDTH, 32: byte-address width.
- DEPTH_WORDS, 65536: number of RAM words. Must be ≤ 2^(ADDR_WIDTH-L).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request valid; sampled only while ready=1.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 0 byte, 1 half, 2 word, 3 double (legal only when DATA_BYTES=8).
- signed_ld  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  W  store data, right-aligned (the low 2^size bytes are used).
- ready  out  1  controller idle; a request is accepted on an edge where req&ready=1.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid only with done; 1 = request rejected.
- rdata  out  W  load result, valid with done; holds its value until the next done.

## Operation
- Lane order is big-endian. The byte at word offset k = addr[L-1:0] occupies bits [W-1-8k -: 8]. An access of n = 2^size bytes at offset k covers lanes k..k+n-1. wdata byte n-1 (the most significant used byte) maps to lane k.
- The request is captured into internal registers on acceptance. After that point, input changes have no effect.
- Error conditions, checked on the captured request:
  - misalignment: addr[size-1:0] ≠ 0;
  - size=3 when DATA_BYTES=4;
  - word index addr[ADDR_WIDTH-1:L] ≥ DEPTH_WORDS.
- On error, no RAM read or write occurs, and rdata is set to 0.
- Load result: the selected lanes are placed right-aligned in rdata. Upper bits are filled with copies of the top selected bit if signed_ld=1, otherwise with 0. A full-width load ignores signed_ld.
- Store merge: the new word is the RAM word with the selected lanes replaced from wdata. All other lanes keep their old values. A full-width store writes wdata unchanged. The read is still performed for a full-width store, so latency is uniform.

State machine:
- IDLE: ready=1. On req, capture the request. If an error condition holds, go to ERR; otherwise go to READ.
- READ: drive the RAM read address. Next state is MERGE if we=1, or LOAD if we=0.
- LOAD: on the leaving edge, load rdata with the extracted value, set done=1 and error=0, then return to IDLE.
- MERGE: on the leaving edge, write the merged word to RAM, set done=1 and error=0, then return to IDLE.
- ERR: on the leaving edge, set done=1, error=1 and rdata=0, then return to IDLE.
- In IDLE, done and error are cleared on the next edge.

## Timing
- Reset (asynchronous): state goes to IDLE; ready=1, done=0, error=0, rdata=0.
  - Any in-flight request is discarded, and a pending store is never written.
  - The RAM is written only on the MERGE leaving edge, so reset asserted before that edge leaves memory unchanged.
- Let E0 be the acceptance edge.
  - Load or store: done is high for exactly the cycle following E2.
  - Error: done is high for the cycle following E1.
- ready is low from E0 until the state returns to IDLE, at E2 (or E1 for errors). The earliest next acceptance is therefore E3 (E2 for errors); sustained throughput is one access per 3 cycles.
- Read-after-write: a store written at its E2 is visible to a load accepted at E3 or later. No bypass is needed.
- req held high while ready=0 is ignored and not queued. The requester must hold req until it sees the accepting edge.
- rdata is unchanged across store completions and holds the last load or error value.

## Test plan
- DATA_BYTES=4:
  - Store word 0xDEADBEEF at 0x10, then load word 0x10 → rdata=0xDEADBEEF, error=0.
  - Done is observed 2 edges after each acceptance; ready is low for 2 cycles.
- Load byte 0x11:
  - unsigned → 0x000000AD;
  - signed → 0xFFFFFFAD;
  - load byte 0x13 signed → 0xFFFFFFEF.
- Store half 0x1234 at 0x12, then load word 0x10 → 0xDEAD1234. Store byte 0x55 at 0x10, then load word → 0x55AD1234.
- Error cases:
  - Load half at 0x13 → done+error 1 edge after acceptance, rdata=0.
  - Store word at 0x12 with 0xFFFFFFFF → error, and word 0x10 is unchanged.
  - size=3 → error.
  - Address 4*DEPTH_WORDS → error.
- Assert reset during MERGE of a store of 0x0 to 0x10 → afterwards ready=1, done=0, rdata=0, and a load of 0x10 still returns 0x55AD1234.
- DATA_BYTES=8:
  - Store double 0x0123456789ABCDEF at 0x20, then load word 0x24 signed → 0xFFFFFFFF89ABCDEF.
  - Load half 0x22 unsigned → 0x0000000000004567.
